prio_q_sorted: RTL and testbench
================================

Name: prio_q_sorted

Overview:
- Parametrised successor to the fixed 16-bit, 31-entry heap priority queue used for PDES event scheduling.
- Holds {key, payload} entries as a register-array sorted list, minimum key at the head.
- Adds payload, same-cycle enqueue+dequeue (replace), stable FIFO ordering for equal keys, and full/empty/error flags.
- Sits between the event generators and the PDES core dispatch; the key is the event timestamp.

Parameters:
- KW, 16, key (timestamp) width in bits; unsigned compare.
- PW, 16, payload width in bits.
- DEPTH, 32, number of entries, >= 2.
- CW, $clog2(DEPTH+1), count width; derived, not overridden.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising CLK.
- enq  input  1  enqueue request.
- enq_key  input  KW  key to insert.
- enq_data  input  PW  payload to insert.
- enq_rdy  output  1  combinational; = !full | deq_acc.
- deq  input  1  dequeue request; pops the head.
- out_valid  output  1  head entry valid; = !empty.
- out_key  output  KW  head key, registered (entry 0).
- out_data  output  PW  head payload, registered.
- count  output  CW  number of valid entries.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- err_ovf  output  1  sticky; enq while !enq_rdy.
- err_udf  output  1  sticky; deq while empty.

Behaviour:
- Reset (rst_n low at a rising edge): all entry valid bits 0, keys/payloads 0, count 0, err_ovf/err_udf 0, out_key/out_data 0, empty 1, full 0. A reset mid-operation discards all contents on that edge; no request in that cycle is accepted.
- deq_acc = deq & !empty.
- enq_acc = enq & (!full | deq_acc).
- Storage: entries 0..DEPTH-1 stay sorted ascending by key and packed; valid entries occupy 0..count-1.
- Each entry i computes ins_here = new key strictly less than entry i key, or entry i invalid.
- Ties use strict compare, so a new key equal to existing keys is placed after all of them (FIFO among equals).
- Enq only: the new entry is written at the first position where ins_here is set; entries at and after that position shift +1; count +1.
- Deq only: all entries shift -1; the last valid slot is cleared; count -1.
- Enq+deq, non-empty: the head is removed and the new entry is inserted into the remaining list in a single cycle.
  - Entry i takes entry i+1, the new entry, or entry i's own value, per the shifted insertion point.
  - count is unchanged.
  - Accepted even when full.
- Enq+deq, empty: deq is ignored and sets err_udf; enq proceeds normally; count becomes 1.
- Enq while full and no deq: request dropped, contents unchanged, err_ovf set.
- Errors: err_ovf and err_udf remain set until reset.
- Latency: an accepted operation is visible on out_key/out_data/count/flags the cycle after the edge (one-cycle latency). A new minimum enqueued at edge N appears at the head after edge N. Back-to-back operations are allowed every cycle.
- out_key/out_data are undefined-but-stable (last cleared value 0) when empty; consumers must gate on out_valid.
- Arithmetic: count is CW bits and never wraps, because overflow and underflow are blocked by enq_acc and deq_acc.

Test Plan:
- Reset, then enq keys 40, 10, 30, 20 (payloads 1-4) on consecutive cycles -> count=4; successive deq yields out_key 10, 20, 30, 40 with payload 2, 4, 3, 1; empty=1 afterwards.
- Enq (7,A), (7,B), (3,C), (7,D) -> deq order C, A, B, D (stable ties).
- Fill DEPTH=32 entries with keys 100..131, then enq key 5 with deq=0 -> full=1, enq_rdy=0, err_ovf=1, head stays 100. Same cycle with deq=1 -> head becomes 5, count stays 32.
- Queue {10, 20, 30}: enq 25 + deq -> next cycle head 20, contents {20, 25, 30}, count=3. Enq 5 + deq on {10, 20} -> head 5, contents {5, 20}.
- Empty queue: deq alone -> err_udf=1, count=0. Enq 9 + deq together -> count=1, head 9.
- Mid-stream reset: queue with 5 entries, rst_n low for one edge while enq=1 -> count=0, empty=1, err flags 0, out_key=0; the enq is not captured.

Source files
------------

// File: rtl/prio_q_sorted_if.sv
// Handshake bundle for the sorted priority queue: enqueue side, head/dequeue side and status.
interface prio_q_sorted_if #(
  parameter int KW    = 16,
  parameter int PW    = 16,
  parameter int DEPTH = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          enq;
  logic [KW-1:0] enq_key;
  logic [PW-1:0] enq_data;
  logic          enq_rdy;
  logic          deq;
  logic          out_valid;
  logic [KW-1:0] out_key;
  logic [PW-1:0] out_data;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          err_ovf;
  logic          err_udf;

  modport master (
    output enq, enq_key, enq_data, deq,
    input  enq_rdy, out_valid, out_key, out_data, count, full, empty, err_ovf, err_udf
  );

  modport slave (
    input  enq, enq_key, enq_data, deq,
    output enq_rdy, out_valid, out_key, out_data, count, full, empty, err_ovf, err_udf
  );
endinterface

// File: rtl/prio_q_sorted.sv
// Register-array sorted priority queue: minimum key at entry 0, FIFO order among equal keys,
// single-cycle enqueue, dequeue and replace (enqueue+dequeue).
module prio_q_sorted #(
  parameter int KW    = 16,
  parameter int PW    = 16,
  parameter int DEPTH = 32
) (
  input logic            CLK,
  input logic            rst_n,
  prio_q_sorted_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          vld_q [DEPTH];
  logic [KW-1:0] key_q [DEPTH];
  logic [PW-1:0] dat_q [DEPTH];
  logic          vld_d [DEPTH];
  logic [KW-1:0] key_d [DEPTH];
  logic [PW-1:0] dat_d [DEPTH];
  logic          vld_up [DEPTH];
  logic [KW-1:0] key_up [DEPTH];
  logic [PW-1:0] dat_up [DEPTH];
  logic          vld_dn [DEPTH];
  logic [KW-1:0] key_dn [DEPTH];
  logic [PW-1:0] dat_dn [DEPTH];

  logic [CW-1:0] count_q, count_d;
  logic          err_ovf_q, err_ovf_d;
  logic          err_udf_q, err_udf_d;
  logic          full, empty, deq_acc, enq_acc;
  logic [DEPTH:0] ins_here;
  logic [DEPTH:0] ins_prev;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign deq_acc = bus.deq & ~empty;
  assign enq_acc = bus.enq & (~full | deq_acc);

  // Strict compare puts a new key after all equal keys; invalid slots always accept.
  // ins_here[DEPTH] is a virtual slot past the end so a full replace can insert last.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ins_here[i] = ~vld_q[i] | (bus.enq_key < key_q[i]);
    end
    ins_here[DEPTH] = 1'b1;
    ins_prev = {ins_here[DEPTH-1:0], 1'b0};

    for (int i = 0; i < DEPTH - 1; i++) begin
      vld_up[i] = vld_q[i+1];
      key_up[i] = key_q[i+1];
      dat_up[i] = dat_q[i+1];
    end
    vld_up[DEPTH-1] = 1'b0;
    key_up[DEPTH-1] = '0;
    dat_up[DEPTH-1] = '0;

    vld_dn[0] = 1'b0;
    key_dn[0] = '0;
    dat_dn[0] = '0;
    for (int i = 1; i < DEPTH; i++) begin
      vld_dn[i] = vld_q[i-1];
      key_dn[i] = key_q[i-1];
      dat_dn[i] = dat_q[i-1];
    end
  end

  always_comb begin
    vld_d     = vld_q;
    key_d     = key_q;
    dat_d     = dat_q;
    count_d   = count_q;
    err_ovf_d = err_ovf_q | (bus.enq & ~enq_acc);
    err_udf_d = err_udf_q | (bus.deq & empty);

    if (enq_acc && deq_acc) begin
      // Replace: slot i sees the list with the head removed, so its neighbour is entry i+1.
      for (int i = 0; i < DEPTH; i++) begin
        if (!ins_here[i+1]) begin
          vld_d[i] = vld_up[i];
          key_d[i] = key_up[i];
          dat_d[i] = dat_up[i];
        end else if (i == 0 || !ins_here[i]) begin
          vld_d[i] = 1'b1;
          key_d[i] = bus.enq_key;
          dat_d[i] = bus.enq_data;
        end
      end
    end else if (enq_acc) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ins_here[i]) begin
          if (!ins_prev[i]) begin
            vld_d[i] = 1'b1;
            key_d[i] = bus.enq_key;
            dat_d[i] = bus.enq_data;
          end else begin
            vld_d[i] = vld_dn[i];
            key_d[i] = key_dn[i];
            dat_d[i] = dat_dn[i];
          end
        end
      end
      count_d = count_q + CW'(1);
    end else if (deq_acc) begin
      vld_d   = vld_up;
      key_d   = key_up;
      dat_d   = dat_up;
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_q[i] <= 1'b0;
        key_q[i] <= '0;
        dat_q[i] <= '0;
      end
      count_q   <= '0;
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      vld_q     <= vld_d;
      key_q     <= key_d;
      dat_q     <= dat_d;
      count_q   <= count_d;
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  assign bus.enq_rdy   = ~full | deq_acc;
  assign bus.out_valid = ~empty;
  assign bus.out_key   = key_q[0];
  assign bus.out_data  = dat_q[0];
  assign bus.count     = count_q;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.err_ovf   = err_ovf_q;
  assign bus.err_udf   = err_udf_q;
endmodule

// File: tb/tb_prio_q_sorted.sv
// Bench for prio_q_sorted: directed stimulus pushes expected heads into a scoreboard queue,
// a negedge monitor pops and compares whenever a dequeue of a valid head is presented.
module tb_prio_q_sorted;
  localparam int KW    = 16;
  localparam int PW    = 16;
  localparam int DEPTH = 32;

  logic CLK   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [KW+PW-1:0] exp_q[$];

  always #5 CLK = ~CLK;

  prio_q_sorted_if #(.KW(KW), .PW(PW), .DEPTH(DEPTH)) bus ();

  prio_q_sorted #(.KW(KW), .PW(PW), .DEPTH(DEPTH)) dut (
    .CLK  (CLK),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Monitor: a head is consumed on any edge where deq is high and out_valid is set.
  always @(negedge CLK) begin
    if (rst_n && bus.deq && bus.out_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL head_pop: got key=%0d data=%0h, expected no dequeue", bus.out_key, bus.out_data);
      end else begin
        logic [KW+PW-1:0] e;
        e = exp_q.pop_front();
        if ({bus.out_key, bus.out_data} !== e) begin
          n_err++;
          $display("FAIL head_pop: got key=%0d data=%0h, expected key=%0d data=%0h",
                   bus.out_key, bus.out_data, e[KW+PW-1:PW], e[PW-1:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    bus.enq = 1'b0;
    bus.deq = 1'b0;
  endtask

  task automatic push(input logic [KW-1:0] k, input logic [PW-1:0] d);
    bus.enq      = 1'b1;
    bus.enq_key  = k;
    bus.enq_data = d;
    step();
  endtask

  task automatic pop(input logic [KW-1:0] ek, input logic [PW-1:0] ed);
    exp_q.push_back({ek, ed});
    bus.deq = 1'b1;
    step();
  endtask

  task automatic rep(input logic [KW-1:0] k, input logic [PW-1:0] d,
                     input logic [KW-1:0] ek, input logic [PW-1:0] ed);
    exp_q.push_back({ek, ed});
    bus.enq      = 1'b1;
    bus.enq_key  = k;
    bus.enq_data = d;
    bus.deq      = 1'b1;
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    bus.enq = 1'b0; bus.deq = 1'b0; bus.enq_key = '0; bus.enq_data = '0;
    repeat (2) @(posedge CLK);
    #1;
    rst_n = 1'b1;

    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_errs", 32'({bus.err_ovf, bus.err_udf}), 0);
    chk("rst_out_key", 32'(bus.out_key), 0);
    chk("rst_enq_rdy", 32'(bus.enq_rdy), 1);

    push(16'd40, 16'd1); push(16'd10, 16'd2); push(16'd30, 16'd3); push(16'd20, 16'd4);
    chk("basic_count", 32'(bus.count), 4);
    chk("basic_head", 32'(bus.out_key), 10);
    pop(16'd10, 16'd2); pop(16'd20, 16'd4); pop(16'd30, 16'd3); pop(16'd40, 16'd1);
    chk("basic_empty", 32'(bus.empty), 1);

    push(16'd7, 16'hA); push(16'd7, 16'hB); push(16'd3, 16'hC); push(16'd7, 16'hD);
    pop(16'd3, 16'hC); pop(16'd7, 16'hA); pop(16'd7, 16'hB); pop(16'd7, 16'hD);
    chk("ties_empty", 32'(bus.empty), 1);

    for (int k = 100; k < 132; k++) push(16'(k), 16'(k));
    chk("fill_full", 32'(bus.full), 1);
    chk("fill_count", 32'(bus.count), 32);
    chk("fill_enq_rdy", 32'(bus.enq_rdy), 0);
    push(16'd5, 16'h55);
    chk("ovf_flag", 32'(bus.err_ovf), 1);
    chk("ovf_head", 32'(bus.out_key), 100);
    chk("ovf_count", 32'(bus.count), 32);
    bus.enq = 1'b1; bus.enq_key = 16'd5; bus.enq_data = 16'h55; bus.deq = 1'b1;
    #1;
    chk("full_rep_enq_rdy", 32'(bus.enq_rdy), 1);
    exp_q.push_back({16'd100, 16'd100});
    step();
    chk("full_rep_head", 32'(bus.out_key), 5);
    chk("full_rep_count", 32'(bus.count), 32);
    pop(16'd5, 16'h55);
    for (int k = 101; k < 132; k++) pop(16'(k), 16'(k));
    chk("drain_empty", 32'(bus.empty), 1);

    do_reset();
    push(16'd10, 16'h10); push(16'd20, 16'h20); push(16'd30, 16'h30);
    rep(16'd25, 16'h25, 16'd10, 16'h10);
    chk("rep_mid_head", 32'(bus.out_key), 20);
    chk("rep_mid_count", 32'(bus.count), 3);
    pop(16'd20, 16'h20); pop(16'd25, 16'h25); pop(16'd30, 16'h30);
    push(16'd10, 16'h10); push(16'd20, 16'h20);
    rep(16'd5, 16'h5, 16'd10, 16'h10);
    chk("rep_min_head", 32'(bus.out_key), 5);
    chk("rep_min_count", 32'(bus.count), 2);
    pop(16'd5, 16'h5); pop(16'd20, 16'h20);
    chk("rep_err_ovf", 32'(bus.err_ovf), 0);

    bus.deq = 1'b1;
    step();
    chk("udf_flag", 32'(bus.err_udf), 1);
    chk("udf_count", 32'(bus.count), 0);
    bus.enq = 1'b1; bus.enq_key = 16'd9; bus.enq_data = 16'h9; bus.deq = 1'b1;
    step();
    chk("empty_rep_count", 32'(bus.count), 1);
    chk("empty_rep_head", 32'(bus.out_key), 9);
    chk("empty_rep_valid", 32'(bus.out_valid), 1);

    push(16'd50, 16'h50); push(16'd51, 16'h51); push(16'd52, 16'h52); push(16'd53, 16'h53);
    chk("pre_rst_count", 32'(bus.count), 5);
    rst_n = 1'b0;
    bus.enq = 1'b1; bus.enq_key = 16'd1; bus.enq_data = 16'h1;
    step();
    rst_n = 1'b1;
    chk("mid_rst_count", 32'(bus.count), 0);
    chk("mid_rst_empty", 32'(bus.empty), 1);
    chk("mid_rst_errs", 32'({bus.err_ovf, bus.err_udf}), 0);
    chk("mid_rst_out_key", 32'(bus.out_key), 0);
    chk("mid_rst_out_data", 32'(bus.out_data), 0);
    step();
    chk("mid_rst_no_capture", 32'(bus.count), 0);

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
